// File: rtl/vdp_vram_writer.sv
// rtl/vdp_vram_writer.sv - CPU write port into VDP VRAM: auto-increment pointer, address/data FIFO, slot-gated drain.
module vdp_vram_writer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_cs,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    input  logic        vram_slot,
    output logic        vram_we,
    output logic [14:0] vram_addr,
    output logic [7:0]  vram_wdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_COUNT = DEPTH;
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW-1:0] IDX_ONE    = 1;

    logic [22:0]   fifo_mem [DEPTH];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [AW:0]   count;
    logic [14:0]   ptr;
    logic [7:0]    stride;
    logic          overflow;

    logic data_wr;
    logic status_rd;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;
    logic [4:0] level;

    assign data_wr   = bus_cs & bus_we & (bus_addr == 2'd2);
    assign status_rd = bus_cs & ~bus_we & (bus_addr == 2'd3);
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign pop       = vram_slot & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push      = data_wr & (~full | pop);
    assign drop      = data_wr & ~push;
    assign level     = 5'(count);

    assign vram_we    = pop;
    assign vram_addr  = fifo_mem[rd_idx][22:8];
    assign vram_wdata = fifo_mem[rd_idx][7:0];

    always_comb begin
        bus_rdata = 8'h00;
        case (bus_addr)
            2'd0:    bus_rdata = ptr[7:0];
            2'd1:    bus_rdata = {1'b0, ptr[14:8]};
            2'd3:    bus_rdata = {full, empty, overflow, level};
            default: bus_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            stride   <= 8'd1;
            overflow <= 1'b0;
        end else begin
            if (bus_cs && bus_we) begin
                case (bus_addr)
                    2'd0:    ptr[7:0]  <= bus_wdata;
                    2'd1:    ptr[14:8] <= bus_wdata[6:0];
                    2'd2:    if (push) ptr <= ptr + {7'd0, stride};
                    default: stride    <= bus_wdata;
                endcase
            end
            // A drop in the same cycle as a status read wins, so the loss is never missed.
            if (drop) begin
                overflow <= 1'b1;
            end else if (status_rd) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= {ptr, bus_wdata};
                wr_idx           <= wr_idx + IDX_ONE;
            end
            if (pop) begin
                rd_idx <= rd_idx + IDX_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_vdp_vram_writer.sv
// tb/tb_vdp_vram_writer.sv - self-checking bench for vdp_vram_writer with a queue-based reference model.
module tb_vdp_vram_writer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_cs = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [7:0]  bus_wdata = 8'd0;
    logic [7:0]  bus_rdata;
    logic        vram_slot = 1'b0;
    logic        vram_we;
    logic [14:0] vram_addr;
    logic [7:0]  vram_wdata;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [14:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t dlog[$];

    logic [22:0] mq[$];
    logic [14:0] mptr = 15'd0;
    logic [7:0]  mstride = 8'd1;
    bit          movf = 1'b0;

    vdp_vram_writer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .vram_slot(vram_slot), .vram_we(vram_we),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_log(input int i, input logic [14:0] a, input logic [7:0] d);
        if (i >= dlog.size()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL log_missing: entry %0d absent, log holds %0d, required addr %0h data %0h", i, dlog.size(), a, d);
        end else begin
            check("log_addr", 32'(dlog[i].a), 32'(a));
            check("log_data", 32'(dlog[i].d), 32'(d));
        end
    endtask

    // Model: FIFO as a queue, pointer as modular arithmetic.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mptr = 15'd0;
            mstride = 8'd1;
            movf = 1'b0;
        end else begin
            int  sz;
            bit  do_pop, dw, sr, dr;
            sz = mq.size();
            do_pop = vram_slot && (sz != 0);
            dw = bus_cs && bus_we && (bus_addr == 2'd2);
            sr = bus_cs && !bus_we && (bus_addr == 2'd3);
            dr = 1'b0;
            if (do_pop) void'(mq.pop_front());
            if (dw) begin
                if (sz < DEPTH || do_pop) begin
                    mq.push_back({mptr, bus_wdata});
                    mptr = 15'((32'(mptr) + 32'(mstride)) % 32768);
                end else begin
                    dr = 1'b1;
                end
            end
            if (bus_cs && bus_we) begin
                if (bus_addr == 2'd0) mptr[7:0] = bus_wdata;
                if (bus_addr == 2'd1) mptr[14:8] = bus_wdata[6:0];
                if (bus_addr == 2'd3) mstride = bus_wdata;
            end
            if (sr) movf = 1'b0;
            if (dr) movf = 1'b1;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_we", 32'(vram_we), 0);
            check("rst_addr", 32'(vram_addr), 0);
            check("rst_wdata", 32'(vram_wdata), 0);
        end else begin
            logic [7:0] exp_rd;
            int sz;
            sz = mq.size();
            check("vram_we", 32'(vram_we), 32'(vram_slot && sz != 0));
            if (sz != 0) begin
                check("head_addr", 32'(vram_addr), 32'(mq[0][22:8]));
                check("head_data", 32'(vram_wdata), 32'(mq[0][7:0]));
            end
            if (bus_cs && !bus_we) begin
                case (bus_addr)
                    2'd0:    exp_rd = mptr[7:0];
                    2'd1:    exp_rd = {1'b0, mptr[14:8]};
                    2'd2:    exp_rd = 8'h00;
                    default: exp_rd = {sz == DEPTH, sz == 0, movf, 5'(sz)};
                endcase
                check("bus_rdata", 32'(bus_rdata), 32'(exp_rd));
            end
            if (vram_we) dlog.push_back('{cyc: cyc, a: vram_addr, d: vram_wdata});
        end
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_cs = 1'b0; bus_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        v = bus_rdata;
        @(posedge clk); #1;
        bus_cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] v;
        #23 reset = 1'b1;
        @(posedge clk); #1;

        rd(2'd3, v);
        check("reset_status", 32'(v), 32'h40);
        check("reset_we", 32'(vram_we), 0);

        vram_slot = 1'b1;
        wr(2'd0, 8'h34);
        wr(2'd1, 8'h12);
        dlog.delete();
        wr(2'd2, 8'hAA);
        wr(2'd2, 8'hBB);
        idle(2);
        check("t2_count", 32'(dlog.size()), 2);
        check_log(0, 15'h1234, 8'hAA);
        check_log(1, 15'h1235, 8'hBB);
        if (dlog.size() == 2) check("t2_consecutive", 32'(dlog[1].cyc - dlog[0].cyc), 1);
        check("model_ptr", 32'(mptr), 32'h1236);
        rd(2'd0, v);
        check("t2_ptr_lo", 32'(v), 32'h36);

        vram_slot = 1'b0;
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h20);
        for (int i = 0; i < DEPTH + 1; i++) wr(2'd2, 8'(8'h10 + i));
        rd(2'd3, v);
        check("t3_status_ovf", 32'(v), 32'hA4);
        rd(2'd3, v);
        check("t3_status_clr", 32'(v), 32'h84);
        dlog.delete();
        vram_slot = 1'b1;
        idle(6);
        check("t3_count", 32'(dlog.size()), 4);
        for (int i = 0; i < 4; i++) check_log(i, 15'(15'h2000 + i), 8'(8'h10 + i));

        wr(2'd0, 8'hFE);
        wr(2'd1, 8'h7F);
        wr(2'd3, 8'h03);
        dlog.delete();
        wr(2'd2, 8'h11);
        wr(2'd2, 8'h22);
        idle(3);
        check("t4_count", 32'(dlog.size()), 2);
        check_log(0, 15'h7FFE, 8'h11);
        check_log(1, 15'h0001, 8'h22);

        vram_slot = 1'b0;
        wr(2'd3, 8'h01);
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h01);
        for (int i = 0; i < 4; i++) wr(2'd2, 8'(8'h60 + i));
        dlog.delete();
        vram_slot = 1'b1;
        wr(2'd2, 8'h55);
        vram_slot = 1'b0;
        rd(2'd3, v);
        check("t5_status", 32'(v), 32'h84);
        vram_slot = 1'b1;
        idle(6);
        check("t5_count", 32'(dlog.size()), 5);
        for (int i = 0; i < 4; i++) check_log(i, 15'(15'h0100 + i), 8'(8'h60 + i));
        check_log(4, 15'h0104, 8'h55);

        vram_slot = 1'b0;
        for (int i = 0; i < 3; i++) wr(2'd2, 8'(8'hC0 + i));
        vram_slot = 1'b1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1 check("t6_we_async", 32'(vram_we), 0);
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        dlog.delete();
        idle(3);
        rd(2'd3, v);
        check("t6_status", 32'(v), 32'h40);
        check("t6_no_writes", 32'(dlog.size()), 0);

        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) vram_slot = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 7) == 0) vram_slot = ~vram_slot;
            bus_cs = ($urandom_range(0, 9) < 7);
            bus_we = $urandom_range(0, 1);
            bus_addr = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'($urandom_range(0, 3));
            bus_wdata = 8'($urandom);
            @(posedge clk); #1;
        end
        bus_cs = 1'b0;
        vram_slot = 1'b1;
        idle(10);
        rd(2'd3, v);
        check("final_empty", 32'(v[6]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vdp_vram_writer.md
# vdp_vram_writer

CPU-facing write port into the VDP's 32 KiB video RAM. It queues CPU writes in a small address/data FIFO with an auto-incrementing pointer. It drains the FIFO into VRAM only during cycles the display fetch leaves free. It is the write side of the VRAM that the scan-out path only reads, and sits between the CPU bus decode and the `spram32k8` write port.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; a power of two, 2..16.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bus_cs`  in  1  register access strobe, one cycle per access.
- `bus_we`  in  1  1 = write, 0 = read; qualified by `bus_cs`.
- `bus_addr`  in  2  register select.
- `bus_wdata`  in  8  write data.
- `bus_rdata`  out  8  read data, combinational from `bus_addr` and state.
- `vram_slot`  in  1  VRAM port free for a write this cycle; driven by the display fetch.
- `vram_we`  out  1  VRAM write enable.
- `vram_addr`  out  15  VRAM write address.
- `vram_wdata`  out  8  VRAM write data.

## Operation

- Register map (write / read):
  - 0 PTR_LO: write sets `ptr[7:0]`; read returns `ptr[7:0]`.
  - 1 PTR_HI: write sets `ptr[14:8]` from `bus_wdata[6:0]`; read returns `{1'b0, ptr[14:8]}`.
  - 2 DATA: write pushes `{ptr, bus_wdata}` into the FIFO; read returns 8'h00.
  - 3 STRIDE/STATUS: write sets `stride`; read returns status.
- Status byte:
  - bit7 full.
  - bit6 empty.
  - bit5 overflow (sticky).
  - bits4:0 level, the FIFO entry count.
- Pointer increment:
  - An accepted DATA write sets `ptr <= (ptr + stride) mod 2^15`; 0x7FFF + 1 wraps to 0x0000.
  - `stride` is 8 bits, zero-extended; stride 0 writes the same address repeatedly.
  - A dropped DATA write does not advance `ptr`.
- FIFO: circular buffer of `DEPTH` entries of 23 bits; read/write indices of log2(DEPTH) bits; count of log2(DEPTH)+1 bits.
- Push accept: a DATA write is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs the same cycle.
- Overflow:
  - A DATA write that is not accepted is dropped and sets `overflow`.
  - A status read (`bus_cs & !bus_we & bus_addr==3`) clears `overflow` at that clock edge. `bus_rdata` still shows the pre-clear value during the read cycle.
  - If a drop and a status read occur in the same cycle, `overflow` ends set.
- Drain:
  - `vram_we = vram_slot & (count != 0)`, combinational.
  - `vram_addr` and `vram_wdata` always present the FIFO head entry.
  - A pop occurs at every edge where `vram_we` is 1.
- Simultaneous push and pop: count is unchanged, both indices advance, and the entry order is preserved.
- PTR writes affect only subsequent DATA writes; entries already queued keep their captured addresses.
- Writes to PTR or STRIDE in the same cycle as the FIFO draining are independent of the drain.

## Timing

- Reset (async, `reset` low), all outputs low:
  - `ptr` = 0, `stride` = 1, `count` = 0, indices = 0, `overflow` = 0.
  - `vram_we` = 0; `vram_addr` = 0 and `vram_wdata` = 0, so FIFO storage resets to 0.
  - Reset asserted mid-drain discards all queued entries; no partial write follows release.
- Reset release: the first register access is honoured on the first rising edge after `reset` goes high.
- Write latency:
  - A DATA write sampled at edge N appears at the FIFO head after edge N when the FIFO was empty.
  - `vram_we` can assert during cycle N+1, giving a 1-cycle minimum bus-to-VRAM latency.
- Pointer timing: `ptr` and register contents update at the sampling edge; a read in the next cycle sees the new value.
- Throughput:
  - One pop per cycle while `vram_slot` is high.
  - Back-to-back DATA writes every cycle are sustained without loss while `vram_slot` stays high.
- `vram_slot` low for any number of cycles holds the FIFO contents; nothing is lost.

## Test plan

- Reset then status read -> `bus_rdata` = 8'h40 (empty, level 0); `vram_we` = 0.
- Write PTR_LO=0x34, PTR_HI=0x12, DATA=0xAA, DATA=0xBB with `vram_slot`=1 -> `vram_we` pulses in two consecutive cycles: (0x1234, 0xAA), then (0x1235, 0xBB). PTR_LO then reads 0x36.
- Hold `vram_slot`=0; write DATA DEPTH+1 times (DEPTH=4) -> status reads 0xA4 (full, overflow, level 4). A second status read returns 0x84. Raising `vram_slot` yields exactly 4 writes at ptr0..ptr0+3.
- Set PTR=0x7FFE, STRIDE=3; write DATA twice -> VRAM writes land at 0x7FFE then 0x0001 (wrap).
- FIFO full with `vram_slot`=1, DATA write in the same cycle as a pop -> write accepted, no overflow, level stays 4, order preserved.
- Assert `reset` low mid-drain with 3 entries queued -> `vram_we` drops immediately; after release, status = 0x40 and no further VRAM writes.
